// File: rtl/cpu_imem_pkg.sv
// cpu_imem_pkg: shared constants and FSM encoding
// for the instruction-memory line buffer.
package cpu_imem_pkg;

  localparam int LINE_WORDS = 4;
  localparam int LINE_IDX_W = 2;
  localparam int TAG_LSB    = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

endpackage

// File: rtl/cpu_imem_line.sv
// cpu_imem_line: one cache line of words with a
// write port, combinational read port, tag and valid.
module cpu_imem_line
  import cpu_imem_pkg::*;
#(
  parameter int WORDS  = LINE_WORDS,
  parameter int IDX_W  = LINE_IDX_W,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 28
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] wdat_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [DATA_W-1:0] rdat_o,
  input  logic              tag_we_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic [TAG_W-1:0]  tag_o,
  input  logic              valid_we_i,
  input  logic              valid_i,
  output logic              valid_o
);

  logic [DATA_W-1:0] words_q [WORDS];
  logic [TAG_W-1:0]  tag_q;
  logic              valid_q;

  // Data words need no reset; valid guards them.
  always_ff @(posedge clk_i) begin
    if (we_i) words_q[widx_i] <= wdat_i;
  end

  // Tag and valid bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (tag_we_i)   tag_q   <= tag_i;
      if (valid_we_i) valid_q <= valid_i;
    end
  end

  assign rdat_o  = words_q[ridx_i];
  assign tag_o   = tag_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/cpu_imem_fill.sv
// cpu_imem_fill: single-line instruction buffer that
// refills over Wishbone classic on a fetch miss.
module cpu_imem_fill #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] imem_address_i,
  output logic [31:0]           imem_data_o,
  output logic                  stall_o,
  input  logic                  flush_i,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i
);

  import cpu_imem_pkg::*;

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_WIDTH - TAG_LSB;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(LINE_WORDS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
  logic                poison_q, poison_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                cyc_q, cyc_d;

  logic [TAG_W-1:0]    addr_tag;
  logic [IDX_W-1:0]    addr_idx;
  logic [TAG_W-1:0]    line_tag;
  logic [31:0]         line_rdat;
  logic                line_valid;
  logic                hit;
  logic                l_we, l_tag_we;
  logic                l_valid_we, l_valid;
  logic                unused_addr;

  assign addr_tag    = imem_address_i[ADDR_WIDTH-1:TAG_LSB];
  assign addr_idx    = imem_address_i[2 +: IDX_W];
  assign unused_addr = ^imem_address_i[1:0];

  assign hit         = line_valid && (addr_tag == line_tag);
  assign imem_data_o = hit ? line_rdat : 32'h0;
  assign stall_o     = !hit;

  assign wb_adr_o = adr_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hF;

  cpu_imem_line #(
    .WORDS  (LINE_WORDS),
    .IDX_W  (IDX_W),
    .DATA_W (32),
    .TAG_W  (TAG_W)
  ) u_line (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .we_i       (l_we),
    .widx_i     (fill_idx_q),
    .wdat_i     (wb_dat_i),
    .ridx_i     (addr_idx),
    .rdat_o     (line_rdat),
    .tag_we_i   (l_tag_we),
    .tag_i      (fill_tag_q),
    .tag_o      (line_tag),
    .valid_we_i (l_valid_we),
    .valid_i    (l_valid),
    .valid_o    (line_valid)
  );

  // FSM and Wishbone master registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      poison_q   <= 1'b0;
      adr_q      <= '0;
      cyc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_idx_q <= fill_idx_d;
      fill_tag_q <= fill_tag_d;
      poison_q   <= poison_d;
      adr_q      <= adr_d;
      cyc_q      <= cyc_d;
    end
  end

  // Miss detection, word-ordered refill, flush/poison.
  always_comb begin
    state_d    = state_q;
    fill_idx_d = fill_idx_q;
    fill_tag_d = fill_tag_q;
    poison_d   = poison_q;
    adr_d      = adr_q;
    cyc_d      = cyc_q;
    l_we       = 1'b0;
    l_tag_we   = 1'b0;
    l_valid_we = 1'b0;
    l_valid    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        poison_d = 1'b0;
        if (flush_i) begin
          l_valid_we = 1'b1;
        end else if (!hit) begin
          fill_tag_d = addr_tag;
          fill_idx_d = '0;
          l_valid_we = 1'b1;
          adr_d      = {addr_tag, {IDX_W{1'b0}}, 2'b00};
          cyc_d      = 1'b1;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (flush_i) poison_d = 1'b1;
        if (wb_ack_i) begin
          l_we       = 1'b1;
          fill_idx_d = fill_idx_q + 1'b1;
          if (fill_idx_q == LAST) begin
            l_tag_we   = 1'b1;
            l_valid_we = 1'b1;
            l_valid    = !(poison_q || flush_i);
            poison_d   = 1'b0;
            cyc_d      = 1'b0;
            state_d    = S_IDLE;
          end else begin
            adr_d = {fill_tag_q, fill_idx_d, 2'b00};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
